// File: rtl/seg_mux_scheduler.sv
// rtl/seg_mux_scheduler.sv - time-multiplexed scan controller for a shared seven-segment decoder
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   run          1 = scan digits, 0 = force all digits off and restart the scan
//   digits_in    nibble k at [4k+3:4k], digit 0 rightmost
//   upd_valid    digits_in is valid
//   upd_ready    a new display value can be accepted
//   hex_sel      nibble of the current digit for the shared decoder
//   enable       active-low digit enables, at most one bit low
//   digit_idx    current digit index
//   frame_start  one-cycle pulse on the first lit cycle of digit 0
module seg_mux_scheduler #(
   parameter int N_DIGITS     = 2,
   parameter int DWELL_CYCLES = 4,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        run,
   input  logic [4*N_DIGITS-1:0]       digits_in,
   input  logic                        upd_valid,
   output logic                        upd_ready,
   output logic [3:0]                  hex_sel,
   output logic [N_DIGITS-1:0]         enable,
   output logic [$clog2(N_DIGITS)-1:0] digit_idx,
   output logic                        frame_start
);

   localparam int IW   = $clog2(N_DIGITS);
   localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [IW-1:0]         idx_n;
   logic [N_DIGITS-1:0]   enable_n;
   logic                  boundary;
   logic [4*N_DIGITS-1:0] shadow, pending;
   logic                  pend_full;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt + CW'(1);
      idx_n    = digit_idx;
      boundary = 1'b0;
      enable_n = '1;
      if (!run) begin
         state_n = BLANK;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         case (state)
            BLANK: begin
               if (cnt == CW'(BLANK_CYCLES - 1)) begin
                  state_n  = SHOW;
                  cnt_n    = '0;
                  // Entering digit 0 is the only point where a new frame may be loaded.
                  boundary = (digit_idx == '0);
               end
            end
            SHOW: begin
               if (cnt == CW'(DWELL_CYCLES - 1)) begin
                  state_n = BLANK;
                  cnt_n   = '0;
                  // Advance while dark so the decoder settles before the next digit lights.
                  idx_n   = (digit_idx == IW'(N_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
               end
            end
            default: begin
               state_n = BLANK;
               cnt_n   = '0;
            end
         endcase
      end
      // Enables come from the next state so they switch exactly on the transition edge.
      for (int k = 0; k < N_DIGITS; k++) begin
         if (state_n == SHOW && idx_n == IW'(k)) enable_n[k] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= BLANK;
         cnt         <= '0;
         digit_idx   <= '0;
         enable      <= '1;
         frame_start <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         digit_idx   <= idx_n;
         enable      <= enable_n;
         frame_start <= boundary;
      end
   end

   // One-deep pending buffer; shadow only changes at a frame boundary so a frame never tears.
   // Data offered on the boundary edge itself lands in pending, never straight in shadow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow    <= '0;
         pending   <= '0;
         pend_full <= 1'b0;
      end else if (boundary && pend_full) begin
         shadow    <= pending;
         pend_full <= 1'b0;
      end else if (upd_valid && !pend_full) begin
         pending   <= digits_in;
         pend_full <= 1'b1;
      end
   end

   assign upd_ready = ~pend_full;

   always_comb begin
      hex_sel = 4'h0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (digit_idx == IW'(k)) hex_sel = shadow[4*k +: 4];
      end
   end

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// tb/tb_seg_mux_scheduler.sv - self-checking bench for seg_mux_scheduler against a timeline model
module tb_seg_mux_scheduler;

   localparam int N  = 2;
   localparam int D  = 4;
   localparam int B  = 2;
   localparam int SP = D + B;
   localparam int P  = N * SP;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [7:0] digits_in;
   logic       upd_valid;
   logic       upd_ready;
   logic [3:0] hex_sel;
   logic [1:0] enable;
   logic [0:0] digit_idx;
   logic       frame_start;

   int checks = 0;
   int errors = 0;

   // Model: cycles since the scan (re)started, plus the display/pending values.
   int         m_t;
   logic [7:0] m_shadow;
   logic [7:0] m_pend;
   logic       m_full;

   logic [1:0] seq_tbl [12] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10,
                                2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};

   seg_mux_scheduler #(.N_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .digits_in   (digits_in),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .hex_sel     (hex_sel),
      .enable      (enable),
      .digit_idx   (digit_idx),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_t = 0; m_shadow = 8'h00; m_pend = 8'h00; m_full = 1'b0;
   endtask

   task automatic check_model();
      int p, dig;
      logic lit;
      logic [1:0] e;
      p   = m_t % P;
      dig = p / SP;
      lit = (p % SP) >= B;
      e   = 2'b11;
      if (lit) e[dig] = 1'b0;
      chk("m_enable", 32'(enable), 32'(e));
      chk("m_digit_idx", 32'(digit_idx), 32'(dig));
      chk("m_frame_start", 32'(frame_start), 32'(p == B));
      chk("m_upd_ready", 32'(upd_ready), 32'(!m_full));
      chk("m_hex_sel", 32'(hex_sel), 32'(m_shadow[dig*4 +: 4]));
      chk("one_hot_low", 32'($countones(~enable) <= 1), 32'(1));
   endtask

   task automatic cycle();
      logic r, v, bnd;
      logic [7:0] d;
      r = run; v = upd_valid; d = digits_in;
      @(posedge clk);
      m_t = r ? m_t + 1 : 0;
      bnd = r && ((m_t % P) == B);
      if (bnd && m_full) begin
         m_shadow = m_pend;
         m_full   = 1'b0;
      end else if (v && !m_full) begin
         m_pend = d;
         m_full = 1'b1;
      end
      #1;
      check_model();
   endtask

   task automatic wait_fs();
      logic found;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (frame_start === 1'b1) found = 1'b1;
      end
      chk("wait_frame_start_timeout", 32'(found), 32'(1));
   endtask

   task automatic wait_en(input logic [1:0] want);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (enable === want) found = 1'b1;
      end
      chk("wait_enable_timeout", 32'(found), 32'(1));
   endtask

   task automatic reset_sequence(input string tag);
      for (int i = 0; i < 24; i++) begin
         cycle();
         chk({tag, "_en"}, 32'(enable), 32'(seq_tbl[(i + 1) % 12]));
         chk({tag, "_fs"}, 32'(frame_start), 32'(((i + 1) % 12) == 2));
      end
   endtask

   initial begin
      reset = 1'b0; run = 1'b1; upd_valid = 1'b0; digits_in = 8'h00;
      m_reset();
      #12;
      chk("rst_enable", 32'(enable), 32'(2'b11));
      chk("rst_hex_sel", 32'(hex_sel), 32'(0));
      chk("rst_upd_ready", 32'(upd_ready), 32'(1));
      chk("rst_frame_start", 32'(frame_start), 32'(0));
      chk("rst_digit_idx", 32'(digit_idx), 32'(0));
      @(negedge clk); reset = 1'b1;
      reset_sequence("seq");

      // Mux data
      digits_in = 8'hA5; upd_valid = 1'b1;
      cycle();
      upd_valid = 1'b0; digits_in = 8'h00;
      chk("a5_ready_drop", 32'(upd_ready), 32'(0));
      wait_fs();
      for (int i = 0; i < P; i++) begin
         if (enable == 2'b10) chk("a5_dig0", 32'(hex_sel), 32'(4'h5));
         if (enable == 2'b01) chk("a5_dig1", 32'(hex_sel), 32'(4'hA));
         cycle();
      end

      // Tear-free update while digit 0 is lit
      wait_fs();
      cycle();
      digits_in = 8'h3C; upd_valid = 1'b1;
      cycle();
      upd_valid = 1'b0; digits_in = 8'hFF;
      chk("3c_ready_drop", 32'(upd_ready), 32'(0));
      wait_en(2'b01);
      chk("3c_old_dig1", 32'(hex_sel), 32'(4'hA));
      wait_fs();
      chk("3c_new_dig0", 32'(hex_sel), 32'(4'hC));
      chk("3c_ready_back", 32'(upd_ready), 32'(1));
      wait_en(2'b01);
      chk("3c_new_dig1", 32'(hex_sel), 32'(4'h3));

      // Backpressure
      digits_in = 8'h11; upd_valid = 1'b1;
      cycle();
      digits_in = 8'h22;
      chk("bp_ready_drop", 32'(upd_ready), 32'(0));
      wait_en(2'b01);
      chk("bp_still_old", 32'(hex_sel), 32'(4'h3));
      wait_fs();
      chk("bp_11_shown", 32'(hex_sel), 32'(4'h1));
      chk("bp_ready_at_bnd", 32'(upd_ready), 32'(1));
      cycle();
      upd_valid = 1'b0;
      chk("bp_22_taken", 32'(upd_ready), 32'(0));
      wait_en(2'b01);
      chk("bp_11_dig1", 32'(hex_sel), 32'(4'h1));
      wait_fs();
      chk("bp_22_shown", 32'(hex_sel), 32'(4'h2));

      // run gating
      wait_en(2'b01);
      run = 1'b0;
      cycle();
      chk("run_off_en", 32'(enable), 32'(2'b11));
      chk("run_off_idx", 32'(digit_idx), 32'(0));
      cycle();
      run = 1'b1;
      cycle();
      chk("run_on_blank", 32'(enable), 32'(2'b11));
      cycle();
      chk("run_on_show", 32'(enable), 32'(2'b10));
      chk("run_on_fs", 32'(frame_start), 32'(1));

      // Async reset mid-SHOW
      cycle();
      #2;
      reset = 1'b0;
      #1;
      chk("areset_en", 32'(enable), 32'(2'b11));
      chk("areset_hex", 32'(hex_sel), 32'(0));
      chk("areset_ready", 32'(upd_ready), 32'(1));
      m_reset();
      @(negedge clk); reset = 1'b1;
      reset_sequence("reseq");

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         upd_valid = 1'($urandom_range(0, 1));
         digits_in = 8'($urandom);
         run       = ($urandom_range(0, 39) != 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
